// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one main-memory port between an I-cache and a D-cache.
// Transactions take at least two SERVE cycles and are always separated by one IDLE cycle.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int BLOCK_WIDTH = 128,
    parameter logic [15:0] COUNT_MAX = 16'hFFFF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_read,
    input  logic [ADDR_WIDTH-1:0]  i_address,
    output logic [BLOCK_WIDTH-1:0] i_readdata,
    output logic                   i_busywait,
    input  logic                   d_read,
    input  logic                   d_write,
    input  logic [ADDR_WIDTH-1:0]  d_address,
    input  logic [BLOCK_WIDTH-1:0] d_writedata,
    output logic [BLOCK_WIDTH-1:0] d_readdata,
    output logic                   d_busywait,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [BLOCK_WIDTH-1:0] mem_writedata,
    input  logic [BLOCK_WIDTH-1:0] mem_readdata,
    input  logic                   mem_busywait,
    output logic [15:0]            i_grant_count,
    output logic [15:0]            d_grant_count
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t state, state_next;
    logic last_i, first, d_req, serve_i, serve_d, i_done, d_done;

    // Reset gates the memory side combinationally so nothing leaks out while it is held.
    assign d_req   = d_read | d_write;
    assign serve_i = reset && state == SERVE_I;
    assign serve_d = reset && state == SERVE_D;
    assign i_done  = serve_i && !first && i_read && !mem_busywait;
    assign d_done  = serve_d && !first && d_req && !mem_busywait;

    assign mem_read      = serve_i ? i_read : (serve_d && d_read && !d_write);
    assign mem_write     = serve_d && d_write;
    assign mem_address   = serve_i ? i_address : serve_d ? d_address : '0;
    assign mem_writedata = serve_d ? d_writedata : '0;
    assign i_busywait    = i_read && !i_done;
    assign d_busywait    = d_req && !d_done;
    assign i_readdata    = i_done ? mem_readdata : '0;
    assign d_readdata    = d_done ? mem_readdata : '0;

    // On a tie, I wins only when D was the last one served.
    always_comb begin
        state_next = state;
        if (state == IDLE)
            state_next = (i_read && (!d_req || !last_i)) ? SERVE_I : d_req ? SERVE_D : IDLE;
        else if ((state == SERVE_I && (!i_read || i_done)) || (state == SERVE_D && (!d_req || d_done)))
            state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            last_i        <= 1'b1;
            first         <= 1'b0;
            i_grant_count <= '0;
            d_grant_count <= '0;
        end else begin
            state <= state_next;
            first <= state == IDLE;
            if (state == IDLE && state_next != IDLE)
                last_i <= state_next == SERVE_I;
            if (i_done && i_grant_count != COUNT_MAX)
                i_grant_count <= i_grant_count + 16'd1;
            if (d_done && d_grant_count != COUNT_MAX)
                d_grant_count <= d_grant_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model (who owns the port, how long it has owned it, grant history).
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int BW = 128;
    localparam logic [15:0] CMAX = 16'd20;

    logic clk = 0, reset = 0, i_read = 0, d_read = 0, d_write = 0, mem_busywait = 0;
    logic [AW-1:0] i_address = '0, d_address = '0;
    logic [BW-1:0] d_writedata = '0, mem_readdata = '0;
    logic [BW-1:0] i_readdata, d_readdata, mem_writedata;
    logic [AW-1:0] mem_address;
    logic i_busywait, d_busywait, mem_read, mem_write;
    logic [15:0] i_grant_count, d_grant_count;

    int checks = 0, errors = 0;
    int owner = -1, age = 0, ci = 0, cd = 0;
    bit last_i = 1;
    logic obs_ib, obs_db, obs_mr, obs_mw;
    logic [AW-1:0] obs_ma;

    mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .COUNT_MAX(CMAX)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait),
        .i_grant_count(i_grant_count), .d_grant_count(d_grant_count)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [BW-1:0] obs, logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check all outputs mid-cycle, then advance the model across the edge.
    task automatic step();
        bit ir, dr, si, sd, idone, ddone;
        #3;
        ir = i_read;
        dr = d_read | d_write;
        si = reset && owner == 0;
        sd = reset && owner == 1;
        idone = si && age > 0 && ir && !mem_busywait;
        ddone = sd && age > 0 && dr && !mem_busywait;
        chk("mem_read", BW'(mem_read), BW'(si ? ir : (sd && d_read && !d_write)));
        chk("mem_write", BW'(mem_write), BW'(sd && d_write));
        chk("mem_address", BW'(mem_address), BW'(si ? i_address : sd ? d_address : '0));
        chk("mem_writedata", mem_writedata, sd ? d_writedata : '0);
        chk("i_busywait", BW'(i_busywait), BW'(ir && !idone));
        chk("d_busywait", BW'(d_busywait), BW'(dr && !ddone));
        chk("i_readdata", i_readdata, idone ? mem_readdata : '0);
        chk("d_readdata", d_readdata, ddone ? mem_readdata : '0);
        chk("i_grant_count", BW'(i_grant_count), BW'(ci));
        chk("d_grant_count", BW'(d_grant_count), BW'(cd));
        obs_ib = i_busywait; obs_db = d_busywait; obs_ma = mem_address;
        obs_mr = mem_read; obs_mw = mem_write;
        @(posedge clk);
        if (!reset) begin
            owner = -1; age = 0; last_i = 1; ci = 0; cd = 0;
        end else if (owner == -1) begin
            if (ir && dr) owner = last_i ? 1 : 0;
            else if (ir) owner = 0;
            else if (dr) owner = 1;
            if (owner != -1) begin
                age = 0;
                last_i = owner == 0;
            end
        end else if (idone || ddone || !(owner == 0 ? ir : dr)) begin
            if (idone && ci < int'(CMAX)) ci++;
            if (ddone && cd < int'(CMAX)) cd++;
            owner = -1;
        end else age++;
        #1;
    endtask

    initial begin
        int t_d, t_i, n;
        logic [AW-1:0] seq [$];
        @(posedge clk); #1;
        reset = 0;
        repeat (2) step();
        chk("reset_i_cnt", BW'(i_grant_count), '0);
        chk("reset_d_cnt", BW'(d_grant_count), '0);
        reset = 1;
        step();

        // Lone I read, memory busy for three serve cycles
        i_read = 1; i_address = 28'h0000010; mem_readdata = {4{32'hCAFE0001}};
        for (int k = 0; k < 12 && ci == 0; k++) begin
            mem_busywait = !(owner == 0 && age >= 3);
            step();
        end
        i_read = 0; mem_busywait = 1;
        step();
        chk("i_cnt_single", BW'(i_grant_count), BW'(16'd1));

        // Simultaneous I and D right after reset: D first
        reset = 0; step(); reset = 1;
        i_read = 1; d_read = 1; d_address = 28'h0000200; mem_busywait = 0;
        t_d = -1; t_i = -1;
        for (int k = 0; k < 20 && (t_d < 0 || t_i < 0); k++) begin
            mem_readdata = {4{$urandom}};
            step();
            if (t_d < 0 && !obs_db) begin t_d = k; d_read = 0; end
            if (t_i < 0 && !obs_ib) begin t_i = k; i_read = 0; end
        end
        chk("d_before_i", BW'(t_d >= 0 && t_i > t_d), BW'(1'b1));
        step();

        // D write-back
        d_write = 1; d_address = 28'h0000ABC;
        d_writedata = {32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0, 32'h00000001};
        n = cd;
        for (int k = 0; k < 12 && cd == n; k++) begin
            mem_busywait = !(owner == 1 && age >= 2);
            step();
            if (owner == 1 && age == 1)
                chk("wb_cmd", BW'({obs_mw, obs_mr, obs_ma}), BW'({1'b1, 1'b0, 28'h0000ABC}));
        end
        chk("d_cnt_wb", BW'(d_grant_count), BW'(n + 1));
        d_write = 0;
        step();

        // Reset in the middle of SERVE_D, request kept asserted
        d_read = 1; mem_busywait = 1;
        repeat (3) step();
        reset = 0; step(); reset = 1;
        chk("rst_mid_wr", BW'(mem_write | mem_read), '0);
        chk("rst_mid_cnt", BW'({i_grant_count, d_grant_count}), '0);
        mem_busywait = 0;
        for (int k = 0; k < 10 && cd == 0; k++) step();
        chk("regrant_after_rst", BW'(d_grant_count), BW'(16'd1));
        d_read = 0; step();

        // Both held continuously: D, I, D, I
        reset = 0; step(); reset = 1;
        i_read = 1; d_read = 1; i_address = 28'h0000111; d_address = 28'h0000222;
        for (int k = 0; k < 14; k++) begin
            step();
            if (obs_mr && (seq.size() == 0 || seq[$] != obs_ma)) seq.push_back(obs_ma);
        end
        chk("alt_len", BW'(seq.size() >= 4), BW'(1'b1));
        for (int k = 0; k < 4 && k < seq.size(); k++)
            chk("alt_order", BW'(seq[k]), BW'(k % 2 == 0 ? 28'h0000222 : 28'h0000111));
        i_read = 0; d_read = 0; step();

        // Saturation of the D counter
        reset = 0; step(); reset = 1;
        d_read = 1;
        for (int k = 0; k < 200 && cd < int'(CMAX); k++) step();
        chk("sat_reach", BW'(d_grant_count), BW'(CMAX));
        repeat (6) step();
        chk("sat_hold", BW'(d_grant_count), BW'(CMAX));
        d_read = 0; step();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            reset = $urandom_range(63) != 0;
            if ($urandom_range(5) == 0) i_read = ~i_read;
            if ($urandom_range(5) == 0) d_read = ~d_read;
            if ($urandom_range(7) == 0) d_write = ~d_write;
            mem_busywait = $urandom_range(1);
            i_address = AW'($urandom); d_address = AW'($urandom);
            d_writedata = {4{$urandom}}; mem_readdata = {4{$urandom}};
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
